// File: rtl/snake_pkg.sv
// Shared types and default constants for the snake prey placer.
// Nothing here depends on SNAKE_PREY_GEN_SEED_EN.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CHECK,
    QWAIT
  } state_t;

  localparam int          DEF_H_LOGIC_WIDTH = 5;
  localparam int          DEF_V_LOGIC_WIDTH = 5;
  localparam logic [4:0]  DEF_H_LOGIC_MAX   = 5'd31;
  localparam logic [4:0]  DEF_V_LOGIC_MAX   = 5'd23;

  localparam int          DEF_LFSR_WIDTH    = 16;
  localparam logic [15:0] DEF_LFSR_TAPS     = 16'h8805;
  localparam logic [15:0] DEF_LFSR_SEED     = 16'hFFF0;
  localparam int          DEF_MAX_TRIES     = 15;

endpackage

// File: rtl/snake_lfsr.sv
// Free-running left-shift Fibonacci LFSR (new bit0 = XOR of tapped bits).
// SNAKE_PREY_GEN_SEED_EN adds a runtime seed load below reset priority.
module snake_lfsr
  import snake_pkg::*;
#(
  parameter int               WIDTH = DEF_LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = DEF_LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEF_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SNAKE_PREY_GEN_SEED_EN
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
`endif
  output logic [WIDTH-1:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
`ifdef SNAKE_PREY_GEN_SEED_EN
    end else if (seed_load) begin
      // An all-zero state would lock the register, so fall back to SEED.
      lfsr <= (seed == '0) ? SEED : seed;
`endif
    end else begin
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    end
  end

endmodule

// File: rtl/snake_prey_gen.sv
// Prey placer: draws LFSR cells, rejects off-field or occupied ones, commits one.
// SNAKE_PREY_GEN_SEED_EN exposes seed_load/seed to reseed the LFSR at run time.
module snake_prey_gen
  import snake_pkg::*;
#(
  parameter int                       H_LOGIC_WIDTH = DEF_H_LOGIC_WIDTH,
  parameter int                       V_LOGIC_WIDTH = DEF_V_LOGIC_WIDTH,
  parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = DEF_H_LOGIC_MAX,
  parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = DEF_V_LOGIC_MAX,
  parameter int                       LFSR_WIDTH    = DEF_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_TAPS     = DEF_LFSR_TAPS,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_SEED     = DEF_LFSR_SEED,
  parameter int                       MAX_TRIES     = DEF_MAX_TRIES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     req,
`ifdef SNAKE_PREY_GEN_SEED_EN
  input  logic                     seed_load,
  input  logic [LFSR_WIDTH-1:0]    seed,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic                     qvalid,
  output logic [H_LOGIC_WIDTH-1:0] qx,
  output logic [V_LOGIC_WIDTH-1:0] qy,
  input  logic                     qhit,
  output logic [H_LOGIC_WIDTH-1:0] preyx,
  output logic [V_LOGIC_WIDTH-1:0] preyy
);

  // Handshakes: req is taken only in IDLE with enb=1; done is a one-cycle
  // pulse and fail is valid only alongside it. qvalid presents qx/qy for one
  // cycle and qhit is sampled on the following edge.

  localparam int CW    = H_LOGIC_WIDTH + V_LOGIC_WIDTH;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_t                   state;
  logic [TRY_W-1:0]         tries;
  logic [H_LOGIC_WIDTH-1:0] cand_x;
  logic [V_LOGIC_WIDTH-1:0] cand_y;
  logic [LFSR_WIDTH-1:0]    lfsr_q;
  logic [CW-1:0]            draw_bits;
  logic                     in_range;
  logic                     give_up;

  snake_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
`ifdef SNAKE_PREY_GEN_SEED_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .lfsr      (lfsr_q)
  );

  // Only the low H+V bits of the LFSR form a candidate cell.
  assign draw_bits = CW'(lfsr_q);
  assign in_range  = ({1'b0, cand_x} <= {1'b0, H_LOGIC_MAX}) &&
                     ({1'b0, cand_y} <= {1'b0, V_LOGIC_MAX});
  assign give_up   = (tries == LAST_TRY);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tries  <= '0;
      cand_x <= '0;
      cand_y <= '0;
      qx     <= '0;
      qy     <= '0;
      qvalid <= 1'b0;
      preyx  <= '0;
      preyy  <= '0;
      done   <= 1'b0;
      fail   <= 1'b0;
    end else if (!enb) begin
      // Paused: everything holds except the completion pulse.
      done <= 1'b0;
      fail <= 1'b0;
    end else begin
      done   <= 1'b0;
      fail   <= 1'b0;
      qvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tries <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          cand_x <= draw_bits[CW-1:V_LOGIC_WIDTH];
          cand_y <= draw_bits[V_LOGIC_WIDTH-1:0];
          state  <= CHECK;
        end
        CHECK: begin
          if (!in_range) begin
            if (give_up) begin
              done  <= 1'b1;
              fail  <= 1'b1;
              state <= IDLE;
            end else begin
              tries <= tries + 1'b1;
              state <= DRAW;
            end
          end else begin
            qvalid <= 1'b1;
            qx     <= cand_x;
            qy     <= cand_y;
            state  <= QWAIT;
          end
        end
        QWAIT: begin
          if (qhit) begin
            if (give_up) begin
              done  <= 1'b1;
              fail  <= 1'b1;
              state <= IDLE;
            end else begin
              tries <= tries + 1'b1;
              state <= DRAW;
            end
          end else begin
            preyx <= cand_x;
            preyy <= cand_y;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_prey_gen.sv
// Bench for snake_prey_gen: scenario tasks checked against a cell-draw model
// built from the LFSR rule and the per-draw timing of accepts and rejections.
module tb_snake_prey_gen;
  import snake_pkg::*;

  localparam int          MT   = 3;
  localparam logic [15:0] SEED = 16'hFFF0;
  localparam logic [15:0] TAPS = 16'h8805;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       req = 1'b0;
  logic       qhit = 1'b0;
  logic       busy, done, fail, qvalid;
  logic [4:0] qx, qy, preyx, preyy;
`ifdef SNAKE_PREY_GEN_SEED_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_lfsr;
  int          occ_mode = 0;
  int          occ_mod = 3;
  logic [4:0]  cur_px = '0;
  logic [4:0]  cur_py = '0;
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  int          e_cyc, e_nq;
  logic        e_fail;
  logic [4:0]  e_px, e_py;

  always #5 clk = ~clk;

  snake_prey_gen #(.MAX_TRIES(MT)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .req       (req),
`ifdef SNAKE_PREY_GEN_SEED_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .qvalid    (qvalid),
    .qx        (qx),
    .qy        (qy),
    .qhit      (qhit),
    .preyx     (preyx),
    .preyy     (preyy)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & TAPS)};
  endfunction

  function automatic logic [15:0] lfsr_ahead(input logic [15:0] l, input int n);
    logic [15:0] v = l;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic bit legal(input logic [15:0] l);
    return (int'(l[9:5]) <= 31) && (int'(l[4:0]) <= 23);
  endfunction

  function automatic bit occupied(input logic [4:0] x, input logic [4:0] y);
    if (occ_mode == 0) return 1'b0;
    if (occ_mode == 1) return 1'b1;
    return ((int'(x) * 7 + int'(y)) % occ_mod) == 0;
  endfunction

  // Reference LFSR: value held after each clock edge.
  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);

  // Offsets count edges after the one that samples req (edge 0). A draw at
  // edge t uses the LFSR value after edge t-1. Off-field: next draw 2 edges
  // later. Queried: answer taken 2 edges after the draw; a hit redraws 3
  // edges later, a miss commits on that edge.
  task automatic predict(input logic [15:0] lt);
    int t = 1;
    int rej = 0;
    int end_t = 0;
    bit fin = 1'b0;
    logic [15:0] l;
    logic [4:0] x, y;
    e_nq = 0; e_fail = 1'b0; e_px = cur_px; e_py = cur_py; e_cyc = -1;
    exp_q.delete();
    while (!fin) begin
      l = lfsr_ahead(lt, t - 1);
      x = l[9:5];
      y = l[4:0];
      if (!legal(l)) begin
        rej++;
        end_t = t + 1;
      end else begin
        exp_q.push_back({x, y});
        e_nq++;
        if (occupied(x, y)) begin
          rej++;
          end_t = t + 2;
        end else begin
          e_cyc = t + 2; e_px = x; e_py = y; fin = 1'b1;
        end
      end
      if (!fin && rej == MT) begin
        e_cyc = end_t; e_fail = 1'b1; fin = 1'b1;
      end
      t = end_t + 1;
    end
  endtask

  // Wait (at negedges) until the next request would start on a wanted draw.
  task automatic find_start(input int kind, output bit ok);
    logic [15:0] nl;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      nl = lfsr_step(m_lfsr);
      if (kind == 0) ok = legal(nl);
      else ok = !legal(nl) && legal(lfsr_ahead(nl, 2));
      if (!ok) @(negedge clk);
    end
  endtask

  // Issue one request from a negedge; acts as the occupancy store and
  // records the queries and the offset of the edge that raised done.
  task automatic drive_req(input int extra_k, output int dcyc, output int nq,
                           output logic f);
    obs_q.delete();
    nq = 0; dcyc = -1; f = 1'b0;
    req = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      req  = (k == extra_k);
      qhit = 1'b0;
      if (qvalid) begin
        nq++;
        obs_q.push_back({qx, qy});
        qhit = occupied(qx, qy);
      end
      if (done) begin
        dcyc = k; f = fail;
        break;
      end
    end
    req = 1'b0; qhit = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enb = 1'b0; req = 1'b0; qhit = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail, qvalid} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, fail, qvalid});
    end
    checks++;
    if ({preyx, preyy} !== 10'd0) begin
      failures++; $display("FAIL reset_prey got=%0d,%0d exp=0,0", preyx, preyy);
    end
    checks++;
    if (dut.lfsr_q !== SEED) begin
      failures++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_q, SEED);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (dut.lfsr_q !== 16'hFE00) begin
      failures++; $display("FAIL lfsr_5 got=%h exp=fe00", dut.lfsr_q);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dut.lfsr_q !== 16'hE001 || dut.lfsr_q !== m_lfsr) begin
      failures++; $display("FAIL lfsr_9 got=%h exp=e001 model=%h", dut.lfsr_q, m_lfsr);
    end
  endtask

  task automatic test_accept_first;
    bit ok; int dcyc, nq; logic f;
    enb = 1'b1; occ_mode = 0;
    find_start(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_search got=none exp=found"); end
    predict(lfsr_step(m_lfsr));
    drive_req(-1, dcyc, nq, f);
    // done shows in the fourth cycle after the edge that samples req.
    checks++;
    if (dcyc !== e_cyc || e_cyc != 3) begin
      failures++; $display("FAIL accept_latency got=%0d exp=%0d", dcyc, e_cyc);
    end
    checks++;
    if (nq !== 1 || f !== 1'b0) begin
      failures++; $display("FAIL accept_query got=nq%0d/f%b exp=nq1/f0", nq, f);
    end
    checks++;
    if (preyx !== e_px || preyy !== e_py) begin
      failures++; $display("FAIL accept_prey got=%0d,%0d exp=%0d,%0d", preyx, preyy, e_px, e_py);
    end
    cur_px = e_px; cur_py = e_py;
  endtask

  task automatic test_range_reject;
    bit ok; int dcyc, nq; logic f;
    occ_mode = 0;
    find_start(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL range_search got=none exp=found"); end
    predict(lfsr_step(m_lfsr));
    drive_req(-1, dcyc, nq, f);
    checks++;
    if (dcyc !== e_cyc || e_cyc != 5) begin
      failures++; $display("FAIL range_latency got=%0d exp=%0d", dcyc, e_cyc);
    end
    checks++;
    if (nq !== 1 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL range_query got=nq%0d exp=nq1 cell=%h", nq, exp_q[0]);
    end
    checks++;
    if (f !== 1'b0 || preyx !== e_px || preyy !== e_py) begin
      failures++; $display("FAIL range_prey got=%0d,%0d f%b exp=%0d,%0d f0", preyx, preyy, f, e_px, e_py);
    end
    cur_px = e_px; cur_py = e_py;
  endtask

  task automatic test_give_up;
    int dcyc, nq; logic f;
    occ_mode = 1;
    predict(lfsr_step(m_lfsr));
    drive_req(-1, dcyc, nq, f);
    checks++;
    if (dcyc !== e_cyc) begin
      failures++; $display("FAIL giveup_latency got=%0d exp=%0d", dcyc, e_cyc);
    end
    checks++;
    if (f !== 1'b1 || nq !== e_nq) begin
      failures++; $display("FAIL giveup_fail got=f%b/nq%0d exp=f1/nq%0d", f, nq, e_nq);
    end
    checks++;
    if (preyx !== cur_px || preyy !== cur_py) begin
      failures++; $display("FAIL giveup_prey got=%0d,%0d exp=%0d,%0d", preyx, preyy, cur_px, cur_py);
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL giveup_pulse got=d%b/f%b exp=d0/f0", done, fail);
    end
    occ_mode = 0;
  endtask

  task automatic test_pause;
    bit ok;
    find_start(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pause_search got=none exp=found"); end
    predict(lfsr_step(m_lfsr));
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.state !== QWAIT) begin
      failures++; $display("FAIL pause_enter got=%0d exp=%0d", dut.state, QWAIT);
    end
    enb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || dut.state !== QWAIT) begin
        failures++; $display("FAIL pause_hold cyc=%0d got=d%b/s%0d exp=d0/s%0d", i, done, dut.state, QWAIT);
      end
    end
    enb = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || preyx !== e_px || preyy !== e_py) begin
      failures++; $display("FAIL pause_commit got=d%b %0d,%0d exp=d1 %0d,%0d", done, preyx, preyy, e_px, e_py);
    end
    cur_px = e_px; cur_py = e_py;
  endtask

  task automatic test_back_to_back;
    int dcyc, nq, gap, extra; logic f;
    occ_mode = 2;
    occ_mod = $urandom_range(2, 4);
    for (int n = 0; n < 8; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      if (gap > 0) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle n=%0d got=%b exp=0", n, busy); end
      end
      predict(lfsr_step(m_lfsr));
      extra = (e_cyc > 1) ? $urandom_range(1, e_cyc - 1) : -1;
      drive_req(extra, dcyc, nq, f);
      checks++;
      if (dcyc !== e_cyc || f !== e_fail) begin
        failures++; $display("FAIL b2b_done n=%0d got=%0d/f%b exp=%0d/f%b", n, dcyc, f, e_cyc, e_fail);
      end
      checks++;
      if (preyx !== e_px || preyy !== e_py) begin
        failures++; $display("FAIL b2b_prey n=%0d got=%0d,%0d exp=%0d,%0d", n, preyx, preyy, e_px, e_py);
      end
      checks++;
      if (nq !== e_nq) begin
        failures++; $display("FAIL b2b_nq n=%0d got=%0d exp=%0d", n, nq, e_nq);
      end else begin
        for (int i = 0; i < nq; i++) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL b2b_cell n=%0d i=%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]);
          end
        end
      end
      cur_px = e_px; cur_py = e_py;
    end
    occ_mode = 0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    find_start(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_search got=none exp=found"); end
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state !== CHECK) begin
      failures++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state, CHECK);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || preyx !== 5'd0 || preyy !== 5'd0) begin
      failures++; $display("FAIL midrst_out got=b%b d%b %0d,%0d exp=b0 d0 0,0", busy, done, preyx, preyy);
    end
    checks++;
    if (dut.lfsr_q !== SEED) begin
      failures++; $display("FAIL midrst_lfsr got=%h exp=%h", dut.lfsr_q, SEED);
    end
    rst = 1'b0;
    cur_px = '0; cur_py = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_accept_first();
    test_range_reject();
    test_give_up();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_prey_gen.md
Name: snake_prey_gen

Overview:
Parametrised prey placer for the snake game logic grid. A free-running Fibonacci LFSR supplies candidate cells. Each candidate is rejected and redrawn if it lies outside the playfield or if the snake-body occupancy lookup reports it as occupied. Sits between the game FSM (request/done handshake) and the snake body store (occupancy query port). Outputs logic-grid coordinates to the renderer.

Parameters:
H_LOGIC_WIDTH, 5, bits of x coordinate
V_LOGIC_WIDTH, 5, bits of y coordinate
H_LOGIC_MAX, 5'd31, largest legal x (inclusive)
V_LOGIC_MAX, 5'd23, largest legal y (inclusive)
LFSR_WIDTH, 16, LFSR length; must be >= H_LOGIC_WIDTH+V_LOGIC_WIDTH
LFSR_TAPS, 16'h8805, feedback tap mask (bits 15,11,2,0)
LFSR_SEED, 16'hFFF0, reset value; must be nonzero
MAX_TRIES, 15, rejections allowed before giving up; minimum 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enb  in  1  FSM advance enable (game pause when 0)
req  in  1  request new prey; sampled only in IDLE with enb=1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a request finishes
fail  out  1  qualifies done: no legal cell found, prey unchanged
qvalid  out  1  occupancy query strobe
qx  out  H_LOGIC_WIDTH  query x
qy  out  V_LOGIC_WIDTH  query y
qhit  in  1  occupancy answer; sampled exactly one cycle after qvalid
preyx  out  H_LOGIC_WIDTH  committed prey x
preyy  out  V_LOGIC_WIDTH  committed prey y

Behaviour:
- Clock clk; reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset state: lfsr=LFSR_SEED, state=IDLE, preyx=0, preyy=0, busy=0, done=0, fail=0, qvalid=0, tries=0.
- LFSR advances every non-reset cycle, independent of enb. Shift left by one; new bit0 = XOR-reduce(lfsr & LFSR_TAPS).
- Candidate extraction: cand_x = lfsr[H+V-1:V], cand_y = lfsr[V-1:0], where H = H_LOGIC_WIDTH and V = V_LOGIC_WIDTH.
- The FSM holds in its current state whenever enb=0. Outputs hold their values, except done, which is forced to 0.
- FSM states:
  - IDLE: on req&enb, clear tries and go to DRAW. Otherwise remain in IDLE.
  - DRAW: register cand_x and cand_y from the LFSR, then go to CHECK.
  - CHECK: if cand_x > H_LOGIC_MAX or cand_y > V_LOGIC_MAX, treat as a rejection. Otherwise drive qvalid=1 with qx=cand_x and qy=cand_y for this cycle only, then go to QWAIT.
  - QWAIT: sample qhit. qhit=1 is a rejection. qhit=0 commits: preyx<=cand_x, preyy<=cand_y, done<=1, then go to IDLE.
- Rejection handling:
  - If tries==MAX_TRIES-1: done<=1, fail<=1, go to IDLE; preyx and preyy are unchanged.
  - Otherwise: tries++ and go back to DRAW.
- Latency: with enb held at 1 and the first candidate accepted, req sampled at edge T gives done=1 during cycle T+4. Each rejection adds 2 cycles from CHECK and 3 cycles from QWAIT.
- done and fail are registered single-cycle pulses. fail=1 only coincides with done=1.
- req while busy=1 is ignored; requests are not queued.
- rst mid-operation: abort immediately to the reset state; no done pulse is issued.
- qx and qy hold the last candidate when qvalid=0.

Optional Feature:
Macro SNAKE_PREY_GEN_SEED_EN.
- Defined: adds input ports seed_load (1 bit) and seed (LFSR_WIDTH bits). seed_load=1 sets lfsr<=seed on the next edge, with priority below rst and above the shift. A seed value of 0 is replaced by LFSR_SEED to avoid lockup. FSM behaviour is unaffected.
- Undefined: these ports do not exist, and the LFSR is seeded only by rst.

Decomposition:
- Package snake_pkg holds:
  - the FSM state enum (IDLE, DRAW, CHECK, QWAIT)
  - the default grid constants (H_LOGIC_WIDTH, V_LOGIC_WIDTH, H_LOGIC_MAX, V_LOGIC_MAX)
  - the default LFSR_TAPS and LFSR_SEED values
- One sub-module, snake_lfsr: parametrised by width, taps and seed. Ports: clk, rst, optional seed load, state out. The top-level FSM instantiates it.

Test Plan:
- Reset and pre-load check: assert rst, then release it. Required: preyx=0, preyy=0, busy=0. After 5 cycles lfsr=0xFE00. After 9 cycles lfsr=0xE001, matching the bench LFSR model.
- Accept on first candidate: hold enb=1 and qhit=0, pulse req at a cycle where the model gives an in-range candidate. Required: qvalid high in exactly one cycle, done at req+4, fail=0, and preyx/preyy equal to the model candidate.
- Range reject: issue req when the model candidate has x≤31 but y≥24. Required: no qvalid for that draw, one redraw, and the committed value is the next in-range model candidate.
- Occupancy reject, then give up: with MAX_TRIES=3, hold qhit=1 throughout. Required: done=1 with fail=1 after exactly 3 rejections, and preyx/preyy unchanged from their previous values.
- Pause: drop enb for 10 cycles while in QWAIT. Required: state held, no done during the pause, and the commit on the first enb=1 cycle.
- Reset mid-operation: assert rst while in CHECK. Required: the next cycle shows busy=0, done=0, prey=0, and lfsr=0xFFF0.
